bcd_write_scheduler: RTL and testbench

Sequencer and arbiter that shares the memory-mapped BCD display peripheral between two requesters. It accepts a 4-bit display value from either requester and arbitrates between them. It then issues the peripheral bus write sequence (load `n`, raise `init`, hold, drop `init`) and signals completion. It sits between the requesting logic and the BCD peripheral's `cs/wr/rd/addr/din` bus.

---
 rtl/bcd_sched_pkg.sv | 31 +++
 rtl/bcd_rr_arbiter.sv | 55 +++++
 rtl/bcd_write_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_bcd_write_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_sched_pkg.sv
// Purpose : shared types and constants for the BCD display write scheduler.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: FSM state encoding, peripheral register addresses, requester
//           count and the hold-length clamp used by the scheduler.
package bcd_sched_pkg;

  // Number of requesters sharing the peripheral.
  localparam int NREQ = 2;

  // Peripheral register map.
  localparam logic [3:0] BCD_ADDR_INIT = 4'h0;  // init control register
  localparam logic [3:0] BCD_ADDR_N    = 4'h2;  // display value register

  // Write sequence: load n, raise init, hold, drop init, report done.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_N     = 3'd1,
    ST_WR_INIT1 = 3'd2,
    ST_HOLD     = 3'd3,
    ST_WR_INIT0 = 3'd4,
    ST_DONE     = 3'd5
  } bcd_state_t;

  // A hold of zero cycles would skip the HOLD state entirely and break the
  // sequence timing, so anything below one is clamped to one.
  function automatic int hold_eff(input int hc);
    return (hc < 1) ? 1 : hc;
  endfunction

endpackage

// File: rtl/bcd_rr_arbiter.sv
// Purpose : picks one of two requesters, one-hot winner output.
// Latency : combinational winner; pointer updates on the grant edge.
// Backpr. : none; losers simply keep req high until served.
// Ports   : req (request vector), win (one-hot winner, zero when no req);
//           with BCD_SCHED_RR_EN also clk, rst_n and adv (grant taken).
// Config  : BCD_SCHED_RR_EN selects round-robin; otherwise requester 0
//           has fixed priority and no pointer exists.
module bcd_rr_arbiter
  import bcd_sched_pkg::*;
(
`ifdef BCD_SCHED_RR_EN
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] win
);

`ifdef BCD_SCHED_RR_EN
  // ptr = 0 favours requester 0, ptr = 1 favours requester 1.
  logic ptr;

  always_comb begin
    win = '0;
    if (ptr && req[1]) begin
      win = 2'b10;
    end else if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end

  // After every grant the favoured side becomes the requester that did not
  // win, so two persistent requesters alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (adv) begin
      ptr <= win[0];
    end
  end
`else
  always_comb begin
    win = '0;
    if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/bcd_write_scheduler.sv
// Purpose : shares the BCD display peripheral between two requesters and
//           drives its cs/wr/addr/din write sequence.
// Latency : gnt one cycle after req is sampled; done HOLD_CYCLES+4 after it.
// Backpr. : requests are only taken in IDLE; req must stay high until gnt.
//
// Ports   : clk, rst_n (async assert, synchronised release)
//           req[1:0], n0, n1       requester side
//           gnt[1:0], done[1:0]    one-cycle pulses back to requesters
//           busy                   sequence in progress
//           cs, wr, rd, addr, dout peripheral bus (rd tied low)
// Config  : BCD_SCHED_RR_EN enables round-robin arbitration (see
//           bcd_rr_arbiter); default is fixed priority to requester 0.
module bcd_write_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int tamPro      = 16,
  parameter int tamAddr     = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [3:0]         n0,
  input  logic [3:0]         n1,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic               busy,
  output logic               cs,
  output logic               wr,
  output logic               rd,
  output logic [tamAddr-1:0] addr,
  output logic [tamPro-1:0]  dout
);

  localparam int HOLD_EFF = hold_eff(HOLD_CYCLES);
  localparam int CW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
  // Counter is loaded with HOLD_EFF-1 and the exit happens on zero, which
  // gives exactly HOLD_EFF cycles in HOLD.
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_EFF - 1);

  localparam logic [tamAddr-1:0] ADDR_N    = tamAddr'(BCD_ADDR_N);
  localparam logic [tamAddr-1:0] ADDR_INIT = tamAddr'(BCD_ADDR_INIT);

  // ------------------------------------------------------------------
  // Reset synchroniser: assertion reaches every flop immediately,
  // release is re-timed to clk through two stages.
  // ------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_s_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_s_n = rst_sync[1];

  // ------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------
  bcd_state_t      state;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] win;      // one-hot winner this cycle
  logic [NREQ-1:0] sel;      // one-hot owner of the sequence in progress
  logic            take;     // a request is accepted on this edge
  logic [3:0]      n_sel;

  assign take  = (state == ST_IDLE) && (|req);
  assign n_sel = win[1] ? n1 : n0;

  bcd_rr_arbiter u_arb (
`ifdef BCD_SCHED_RR_EN
    .clk   (clk),
    .rst_n (rst_s_n),
    .adv   (take),
`endif
    .req   (req),
    .win   (win)
  );

  // The peripheral never gets read.
  assign rd = 1'b0;

  // ------------------------------------------------------------------
  // Sequencer. Every output is a flop set on the transition into the
  // state it belongs to, so the bus is glitch-free and settled well
  // before the peripheral's falling-edge sample.
  // The display value is captured straight into dout on the IDLE->WR_N
  // edge; that register is the only copy, so later n0/n1 changes cannot
  // leak into the sequence.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel   <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      cs    <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      dout  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state <= ST_WR_N;
            sel   <= win;
            gnt   <= win;
            busy  <= 1'b1;
            cs    <= 1'b1;
            wr    <= 1'b1;
            addr  <= ADDR_N;
            dout  <= tamPro'(n_sel);
          end
        end

        ST_WR_N: begin
          // Second write back-to-back: raise init.
          state <= ST_WR_INIT1;
          gnt   <= '0;
          addr  <= ADDR_INIT;
          dout  <= tamPro'(1'b1);
        end

        ST_WR_INIT1: begin
          state <= ST_HOLD;
          cnt   <= HOLD_LOAD;
          cs    <= 1'b0;
          wr    <= 1'b0;
          addr  <= '0;
          dout  <= '0;
        end

        ST_HOLD: begin
          if (cnt == '0) begin
            // Leaving HOLD: drop init on the next cycle.
            state <= ST_WR_INIT0;
            cs    <= 1'b1;
            wr    <= 1'b1;
            addr  <= ADDR_INIT;
            dout  <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_WR_INIT0: begin
          state <= ST_DONE;
          cs    <= 1'b0;
          wr    <= 1'b0;
          addr  <= '0;
          done  <= sel;
        end

        ST_DONE: begin
          state <= ST_IDLE;
          done  <= '0;
          busy  <= 1'b0;
          sel   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          sel   <= '0;
          gnt   <= '0;
          done  <= '0;
          busy  <= 1'b0;
          cs    <= 1'b0;
          wr    <= 1'b0;
          addr  <= '0;
          dout  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_write_scheduler.sv
// Testbench for bcd_write_scheduler: table-driven single request, directed
// multi-cycle sequences, and randomized traffic checked each cycle against
// a transaction-level model. dut_a uses HOLD_CYCLES=4, dut_b HOLD_CYCLES=0.
module tb_bcd_write_scheduler;

  localparam int H = 4;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        busy;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [15:0] dout;
  } obs_t;

  typedef struct {
    logic [1:0] req;
    logic [3:0] n0;
    obs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] b_req = 2'b00;
  logic [3:0] n0 = 4'h0;
  logic [3:0] n1 = 4'h0;

  logic [1:0] a_gnt, a_done, b_gnt, b_done;
  logic a_busy, a_cs, a_wr, a_rd, b_busy, b_cs, b_wr, b_rd;
  logic [3:0] a_addr, b_addr;
  logic [15:0] a_dout, b_dout;
  obs_t a_obs, b_obs;

  assign a_obs = {a_gnt, a_done, a_busy, a_cs, a_wr, a_rd, a_addr, a_dout};
  assign b_obs = {b_gnt, b_done, b_busy, b_cs, b_wr, b_rd, b_addr, b_dout};

  always #5 clk = ~clk;

  bcd_write_scheduler #(.tamPro(16), .tamAddr(4), .HOLD_CYCLES(H)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .n0(n0), .n1(n1),
    .gnt(a_gnt), .done(a_done), .busy(a_busy), .cs(a_cs), .wr(a_wr),
    .rd(a_rd), .addr(a_addr), .dout(a_dout)
  );

  bcd_write_scheduler #(.tamPro(16), .tamAddr(4), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .n0(n0), .n1(n1),
    .gnt(b_gnt), .done(b_done), .busy(b_busy), .cs(b_cs), .wr(b_wr),
    .rd(b_rd), .addr(b_addr), .dout(b_dout)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic obs_t ob(input logic [1:0] g, input logic [1:0] d, input logic b,
                              input logic c, input logic w, input logic [3:0] a,
                              input logic [15:0] dt);
    obs_t o;
    o.gnt = g; o.done = d; o.busy = b; o.cs = c; o.wr = w; o.rd = 1'b0;
    o.addr = a; o.dout = dt;
    return o;
  endfunction

  // Expected bus/handshake picture p cycles into a sequence of hold length h.
  function automatic obs_t phase_out(input int p, input int w, input logic [3:0] v, input int h);
    logic [1:0] oh;
    oh = (w == 1) ? 2'b10 : 2'b01;
    if (p == 0)                 return ob(oh, 2'b00, 1, 1, 1, 4'h2, {12'h000, v});
    else if (p == 1)            return ob(2'b00, 2'b00, 1, 1, 1, 4'h0, 16'h0001);
    else if (p >= 2 && p <= h + 1) return ob(2'b00, 2'b00, 1, 0, 0, 4'h0, 16'h0000);
    else if (p == h + 2)        return ob(2'b00, 2'b00, 1, 1, 1, 4'h0, 16'h0000);
    else if (p == h + 3)        return ob(2'b00, oh, 1, 0, 0, 4'h0, 16'h0000);
    else                        return '0;
  endfunction

  // ---------------- transaction-level reference model (dut_a) ----------
  int e_cnt = 0, start_e = 0, next_free = 0, rel_cnt = 0, mw = 0;
  bit mact = 0;
  logic [3:0] mv = 4'h0;
  obs_t m_exp = '0;
  bit chk_en = 0;
`ifdef BCD_SCHED_RR_EN
  bit mptr = 0;
`endif

  always @(posedge clk) begin
    e_cnt++;
    if (!rst_n) begin
      mact = 0; next_free = 0; rel_cnt = 0;
`ifdef BCD_SCHED_RR_EN
      mptr = 0;
`endif
    end else begin
      // Two-stage release synchroniser: third edge after release is live.
      if (rel_cnt >= 2 && e_cnt >= next_free && req != 2'b00) begin
`ifdef BCD_SCHED_RR_EN
        if (req == 2'b11) mw = int'(mptr);
        else mw = req[1] ? 1 : 0;
        mptr = (mw == 0);
`else
        mw = req[0] ? 0 : 1;
`endif
        mv = (mw == 1) ? n1 : n0;
        start_e = e_cnt;
        next_free = e_cnt + 5 + H;
        mact = 1;
      end
      if (rel_cnt < 2) rel_cnt++;
    end
    m_exp = mact ? phase_out(e_cnt - start_e, mw, mv, H) : '0;
  end

  always @(negedge clk) begin
    if (chk_en) chk("model_cycle", 32'(a_obs), rst_n ? 32'(m_exp) : 32'd0);
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Counts rising edges until gnt[idx] (or done[idx]) is seen; -1 on timeout.
  task automatic wait_ev(input bit is_done, input int idx, input int budget,
                         output int cyc, output logic [15:0] dat);
    cyc = -1; dat = 16'h0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if ((is_done ? a_done[idx] : a_gnt[idx]) === 1'b1) begin
        cyc = c; dat = a_dout; break;
      end
    end
  endtask

  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    vec_t tbl[10];
    int cyc, cyc2, cnt_a, cnt_b, ng;
    logic [15:0] dat, dat2;
    int gq[3];
    logic [15:0] dq[3];
    int eg[3];
    logic [15:0] ed[3];

    // Single request, n0=7, hold 4: gnt k+1, writes k+1/k+2/k+7, done k+8.
    tbl[0] = '{2'b00, 4'h0, ob(0, 0, 0, 0, 0, 4'h0, 16'h0)};
    tbl[1] = '{2'b01, 4'h7, ob(2'b01, 0, 1, 1, 1, 4'h2, 16'h7)};
    tbl[2] = '{2'b00, 4'h7, ob(0, 0, 1, 1, 1, 4'h0, 16'h1)};
    tbl[3] = '{2'b00, 4'h7, ob(0, 0, 1, 0, 0, 4'h0, 16'h0)};
    tbl[4] = '{2'b00, 4'h7, ob(0, 0, 1, 0, 0, 4'h0, 16'h0)};
    tbl[5] = '{2'b00, 4'h7, ob(0, 0, 1, 0, 0, 4'h0, 16'h0)};
    tbl[6] = '{2'b00, 4'h7, ob(0, 0, 1, 0, 0, 4'h0, 16'h0)};
    tbl[7] = '{2'b00, 4'h7, ob(0, 0, 1, 1, 1, 4'h0, 16'h0)};
    tbl[8] = '{2'b00, 4'h7, ob(0, 2'b01, 1, 0, 0, 4'h0, 16'h0)};
    tbl[9] = '{2'b00, 4'h7, ob(0, 0, 0, 0, 0, 4'h0, 16'h0)};

`ifdef BCD_SCHED_RR_EN
    eg = '{0, 1, 0}; ed = '{16'h3, 16'h9, 16'h3};
`else
    eg = '{0, 0, 0}; ed = '{16'h3, 16'h3, 16'h3};
`endif

    // Reset state (async assertion).
    #3 rst_n = 1'b0;
    #1 chk("reset_state", 32'(a_obs), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_en = 1;

    // ---- table-driven single request ----
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req; n0 = tbl[i].n0;
      @(posedge clk); #1;
      chk($sformatf("single_row%0d", i), 32'(a_obs), 32'(tbl[i].exp));
      @(negedge clk);
    end

    // ---- contention from reset ----
    do_reset();
    req = 2'b11; n0 = 4'h3; n1 = 4'h9; ng = 0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      @(posedge clk); #1;
      if (a_gnt != 2'b00) begin
        gq[ng] = a_gnt[1] ? 1 : 0; dq[ng] = a_dout; ng++;
      end
    end
    @(negedge clk); req = 2'b00;
    chk("contention_count", ng, 3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("contention_gnt%0d", j), gq[j], eg[j]);
      chk($sformatf("contention_dat%0d", j), dq[j], ed[j]);
    end
    repeat (12) @(negedge clk);

    // ---- late request: req[1] rises during HOLD of requester 0 ----
    req = 2'b01; n0 = 4'h4;
    wait_ev(0, 0, 10, cyc, dat);
    chk("late_gnt0_lat", cyc, 1);
    chk("late_gnt0_dat", dat, 16'h4);
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    @(negedge clk); req = 2'b10; n1 = 4'hA;
    wait_ev(0, 1, 30, cyc2, dat2);
    chk("late_gnt1_lat", cyc2, H + 3);
    chk("late_gnt1_dat", dat2, 16'hA);
    @(negedge clk); req = 2'b00;
    repeat (12) @(negedge clk);

    // ---- value change after grant ----
    req = 2'b01; n0 = 4'h5;
    wait_ev(0, 0, 10, cyc, dat);
    chk("valchg_dat", dat, 16'h5);
    @(negedge clk); req = 2'b00; n0 = 4'h2;
    cnt_a = 0; cnt_b = 0;
    repeat (H + 5) begin
      @(posedge clk); #1;
      if (a_cs && a_wr && a_addr == 4'h2) cnt_a++;
      if (a_done[0]) cnt_b++;
    end
    chk("valchg_no_rewrite", cnt_a, 0);
    chk("valchg_done", cnt_b, 1);
    repeat (3) @(negedge clk);

    // ---- reset during HOLD ----
    req = 2'b01; n0 = 4'h6;
    wait_ev(0, 0, 10, cyc, dat);
    @(negedge clk); req = 2'b00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midreset_zero", 32'(a_obs), 32'd0);
    cnt_a = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_done != 2'b00 || a_busy) cnt_a++;
    end
    chk("midreset_no_done", cnt_a, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    req = 2'b01; n0 = 4'h8;
    wait_ev(0, 0, 10, cyc, dat);
    chk("postreset_gnt", cyc, 1);
    chk("postreset_dat", dat, 16'h8);
    @(negedge clk); req = 2'b00;
    wait_ev(1, 0, 20, cyc, dat);
    chk("postreset_done_lat", cyc, H + 3);
    repeat (4) @(negedge clk);

    // ---- randomized traffic, checked by the model every cycle ----
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (a_gnt[i]) req[i] = 1'b0;
        end else begin
          if (i == 0) n0 = 4'($urandom_range(0, 15));
          else        n1 = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end
      end
    end
    @(negedge clk); req = 2'b00;
    repeat (15) @(negedge clk);

    // ---- HOLD_CYCLES=0 behaves as 1: done at k+5 ----
    b_req = 2'b01; n0 = 4'hC;
    for (int p = 0; p < 6; p++) begin
      @(posedge clk); #1;
      chk($sformatf("hold0_p%0d", p), 32'(b_obs), 32'(phase_out(p, 0, 4'hC, 1)));
      if (p == 0) begin @(negedge clk); b_req = 2'b00; end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
